// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// Latency: 1 cycle from accept to out_* (falling-edge registered), strict FIFO order.
// Backpressure: in_ready = !skid_valid; at most one extra entry is absorbed after out_ready drops.
//
// Ports:
//   clock        stage clock; all state updates on the falling edge
//   reset        synchronous active-high reset, sampled on the falling edge
//   flush        synchronous squash of held entries (ctrl zeroed, data held)
//   in_valid/in_ready/in_data/in_ctrl      upstream handshake and payload
//   out_valid/out_ready/out_data/out_ctrl  downstream handshake and payload
//   occupancy    number of entries held (0..2)
//   stall_count  saturating count of edges with out_valid & !out_ready
//                (present only when PERF_CNT_EN is defined)
module pipe_stage_reg #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 2
`ifdef PERF_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_count
`endif
);

  // State encoding is {main_valid, skid_valid}; 2'b01 cannot be reached.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    TWO   = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [1:0]          occ_q, occ_d;

  logic main_valid;
  logic skid_valid;
  logic accept;
  logic emit;

  assign main_valid = state_q[1];
  assign skid_valid = state_q[0];

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign occupancy = occ_q;

  assign accept = in_valid & in_ready;
  assign emit   = main_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (flush) begin
      // Squash everything; data fields keep their last value, any accept
      // in this cycle is dropped.
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (accept) begin
            // Downstream stalled: park the new entry in the skid slot.
            state_d     = TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (emit) begin
            // Main drains with nothing behind it: insert a bubble.
            state_d     = EMPTY;
            main_ctrl_d = '0;
          end
        end
        TWO: begin
          // in_ready is low here, so only the emit path matters.
          if (emit) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_ctrl_d = '0;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end

    occ_d = {1'b0, state_d[1]} + {1'b0, state_d[0]};
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      occ_q       <= occ_d;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;

  // Counts edges where the main entry is blocked downstream; saturates and
  // is deliberately immune to flush.
  always_ff @(negedge clock) begin
    if (reset) begin
      stall_q <= '0;
    end else if (main_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int DATA_W = 69;
  localparam int CTRL_W = 2;

  logic              clock;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
`ifdef PERF_CNT_EN
  logic [3:0]        stall_count;
`endif

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  pipe_stage_reg #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
`ifdef PERF_CNT_EN
    ,
    .CNT_W(4)
`endif
  ) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_ctrl(in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_ctrl(out_ctrl),
    .occupancy(occupancy)
`ifdef PERF_CNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One active (falling) edge, then return to the following rising edge,
  // where outputs are stable and new inputs are driven.
  task automatic tick();
    @(negedge clock);
    @(posedge clock);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [CTRL_W-1:0] c,
                         input logic [1:0] occ, input logic ir);
    chk({tag, ".out_valid"}, 128'(out_valid), 128'(v));
    chk({tag, ".out_ctrl"},  128'(out_ctrl),  128'(c));
    chk({tag, ".occupancy"}, 128'(occupancy), 128'(occ));
    chk({tag, ".in_ready"},  128'(in_ready),  128'(ir));
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;
    @(posedge clock);
    tick();
    chk_out("reset", 1'b0, 2'b00, 2'd0, 1'b1);
    chk("reset.out_data", 128'(out_data), 128'd0);
`ifdef PERF_CNT_EN
    chk("reset.stall_count", 128'(stall_count), 128'd0);
`endif
    reset = 1'b0;

    // Streaming at full rate: each value appears one edge after it is accepted.
    in_valid  = 1'b1;
    in_ctrl   = 2'b11;
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_data = DATA_W'(i);
      tick();
      chk_out($sformatf("stream%0d", i), 1'b1, 2'b11, 2'd1, 1'b1);
      chk($sformatf("stream%0d.out_data", i), 128'(out_data), 128'(i));
    end
    in_valid = 1'b0;
    tick();
    chk_out("stream_drain", 1'b0, 2'b00, 2'd0, 1'b1);
    chk("stream_drain.out_data_held", 128'(out_data), 128'd5);

    // Back-pressure: 10 in main, 11 in skid, 12 held upstream.
    in_valid  = 1'b1;
    in_ctrl   = 2'b10;
    in_data   = DATA_W'(10);
    out_ready = 1'b1;
    tick();
    chk("bp_first.out_data", 128'(out_data), 128'd10);
    in_data   = DATA_W'(11);
    out_ready = 1'b0;
    tick();
    chk_out("bp_two", 1'b1, 2'b10, 2'd2, 1'b0);
    chk("bp_two.out_data", 128'(out_data), 128'd10);
    in_data = DATA_W'(12);
    tick();
    chk_out("bp_hold", 1'b1, 2'b10, 2'd2, 1'b0);
    chk("bp_hold.out_data", 128'(out_data), 128'd10);
    out_ready = 1'b1;
    tick();
    chk_out("bp_rel1", 1'b1, 2'b10, 2'd1, 1'b1);
    chk("bp_rel1.out_data", 128'(out_data), 128'd11);
    tick();
    chk_out("bp_rel2", 1'b1, 2'b10, 2'd1, 1'b1);
    chk("bp_rel2.out_data", 128'(out_data), 128'd12);
    in_valid = 1'b0;
    tick();
    chk_out("bp_empty", 1'b0, 2'b00, 2'd0, 1'b1);

    // Bubble: single accept, control visible for one cycle then zeroed.
    in_valid = 1'b1;
    in_ctrl  = 2'b01;
    in_data  = DATA_W'(8'h33);
    tick();
    chk_out("bubble_on", 1'b1, 2'b01, 2'd1, 1'b1);
    in_valid = 1'b0;
    tick();
    chk_out("bubble_off", 1'b0, 2'b00, 2'd0, 1'b1);
    chk("bubble_off.out_data_held", 128'(out_data), 128'h33);

    // Flush while full, with a live input that must be discarded.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 2'b11;
    in_data   = DATA_W'(8'h20);
    tick();
    in_data = DATA_W'(8'h21);
    tick();
    chk_out("flush_pre", 1'b1, 2'b11, 2'd2, 1'b0);
    flush   = 1'b1;
    in_data = DATA_W'(8'h55);
    tick();
    chk_out("flush", 1'b0, 2'b00, 2'd0, 1'b1);
    chk("flush.out_data_held", 128'(out_data), 128'h20);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk_out("flush_after", 1'b0, 2'b00, 2'd0, 1'b1);
    chk("flush_after.no_55", 128'(out_data), 128'h20);

    // Reset mid-operation while full and stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 2'b10;
    in_data   = DATA_W'(8'h30);
    tick();
    in_data = DATA_W'(8'h31);
    tick();
    chk("rst_pre.occupancy", 128'(occupancy), 128'd2);
    reset = 1'b1;
    tick();
    chk_out("rst_mid", 1'b0, 2'b00, 2'd0, 1'b1);
    chk("rst_mid.out_data", 128'(out_data), 128'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    in_ctrl   = 2'b01;
    in_data   = DATA_W'(7);
    tick();
    chk_out("rst_after", 1'b1, 2'b01, 2'd1, 1'b1);
    chk("rst_after.out_data", 128'(out_data), 128'd7);
    in_valid = 1'b0;
    tick();
    chk_out("rst_after_drain", 1'b0, 2'b00, 2'd0, 1'b1);

`ifdef PERF_CNT_EN
    // Stall counter saturates at 15, survives flush, cleared by reset.
    chk("perf_start", 128'(stall_count), 128'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = DATA_W'(9);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("perf_sat", 128'(stall_count), 128'd15);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("perf_flush", 128'(stall_count), 128'd15);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("perf_reset", 128'(stall_count), 128'd0);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
